serial_subtractor: RTL and testbench
====================================

SERIAL_SUBTRACTOR -- requirements
Module: serial_subtractor

Interface
REQ-001 Parameter: WIDTH, default 8, operand and result width in bits; legal range 1..32.
REQ-002 Port: clk  input  1  single clock; all state updates on the rising edge.
REQ-003 Port: rst_n  input  1  reset, asynchronous assertion, active-low.
REQ-004 Port: start  input  1  request to subtract; sampled only in IDLE.
REQ-005 Port: a  input  WIDTH  minuend; captured on the accepted start edge.
REQ-006 Port: b  input  WIDTH  subtrahend; captured on the accepted start edge.
REQ-007 Port: diff  output  WIDTH  result a-b modulo 2^WIDTH; registered.
REQ-008 Port: borrow  output  1  final borrow-out, 1 when a<b unsigned; registered.
REQ-009 Port: busy  output  1  high while in SHIFT or DONE.
REQ-010 Port: done  output  1  single-cycle pulse when diff/borrow are valid.

Function
REQ-011 SHALL implement FSM states IDLE, SHIFT, DONE.
REQ-012 IDLE: on start=1 at a rising edge, load a and b into shift registers, clear the borrow flip-flop, clear the bit counter, and go to SHIFT.
REQ-013 SHIFT: each edge processes one bit, LSB first: d = a0^b0^bin; bout = (~a0&b0) | (~(a0^b0)&bin).
REQ-014 SHIFT: shift d into the diff register from the MSB end, store bout, shift both operand registers right by 1, and increment the counter.
REQ-015 SHIFT SHALL last exactly WIDTH edges, then go to DONE; counter width is clog2(WIDTH+1).
REQ-016 DONE SHALL last exactly one cycle with done=1, then return to IDLE.
REQ-017 Latency: start sampled at edge k gives done=1 in the cycle after edge k+WIDTH; next start is accepted at edge k+WIDTH+2 at the earliest.
REQ-018 diff and borrow SHALL hold their final values from DONE until the next accepted start edge.
REQ-019 diff SHALL hold intermediate partial values during SHIFT and is not valid until done.
REQ-020 start asserted in SHIFT or DONE SHALL be ignored, with no queueing; a and b changing during SHIFT SHALL have no effect.
REQ-021 start held high continuously SHALL start back-to-back operations, each accepted on entry to IDLE.
REQ-022 WIDTH=1: SHIFT lasts one cycle; behaviour is otherwise identical.

Reset
REQ-023 rst_n=0 SHALL immediately force IDLE, diff=0, borrow=0, busy=0, done=0, and clear the counter and shift registers.
REQ-024 Reset mid-SHIFT SHALL abort the operation with no done pulse; the first start after rst_n rises is accepted normally.

Structure
REQ-025 A shared package SHALL hold the state encoding constants (IDLE=2'd0, SHIFT=2'd1, DONE=2'd2) and the WIDTH default.
REQ-026 The per-bit cell SHALL be a sub-module half_subtractor (diff=a^b, borrow=~a&b).
REQ-027 Two half_subtractor instances plus an OR SHALL form the full-subtract cell; there is no other hierarchy.

Verification
REQ-028 WIDTH=8, a=100, b=37, start 1 cycle -> done after 8 SHIFT edges, diff=63, borrow=0, busy low next cycle.
REQ-029 a=37, b=100 -> diff=193 (8'hC1), borrow=1; a=0, b=255 -> diff=1, borrow=1; a=0, b=0 -> diff=0, borrow=0.
REQ-030 Pulse start again 3 cycles into SHIFT with a=5, b=1 -> ignored; result still from the first operands; exactly one done pulse.
REQ-031 Drop rst_n at SHIFT edge 4 of a=200, b=50 -> outputs 0 and state IDLE at once, no done; then a=200, b=50 -> diff=150, borrow=0.
REQ-032 start held high for 3 operations -> done pulses spaced exactly WIDTH+2 cycles apart, each result correct.
REQ-033 WIDTH=1 exhaustive over the 4 {a,b} pairs -> (diff,borrow) = (0,0),(1,1),(1,0),(0,0) for a,b = 00,01,10,11; done 2 cycles after start.

Source files
------------

// File: rtl/serial_subtractor_pkg.sv
// Shared constants for the bit-serial subtractor: FSM encoding and default width.
package serial_subtractor_pkg;

  localparam int DEF_WIDTH = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

endpackage

// File: rtl/half_subtractor.sv
// One-bit half subtractor; two of these plus an OR make the full-subtract cell.
module half_subtractor (
  input  logic a,
  input  logic b,
  output logic diff,
  output logic borrow
);

  assign diff   = a ^ b;
  assign borrow = ~a & b;

endmodule

// File: rtl/serial_subtractor.sv
// Bit-serial a-b: one bit per clock, LSB first, result shifted in from the MSB end.
module serial_subtractor
  import serial_subtractor_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] diff,
  output logic             borrow,
  output logic             busy,
  output logic             done
);

  localparam int CW = $clog2(WIDTH + 1);

  state_t           state, state_nxt;
  logic [WIDTH-1:0] a_q, b_q, diff_q, diff_sh;
  logic             bin_q;
  logic [CW-1:0]    cnt_q;
  logic             last;
  logic             d1, br1, d, br2, bout;

  // Full-subtract cell: (a0 - b0) first, then subtract the incoming borrow.
  half_subtractor u_hs0 (.a(a_q[0]), .b(b_q[0]), .diff(d1), .borrow(br1));
  half_subtractor u_hs1 (.a(d1),     .b(bin_q),  .diff(d),  .borrow(br2));
  assign bout = br1 | br2;

  // Counter reaches WIDTH-1 on the edge before the final bit is processed.
  assign last = (cnt_q == CW'(WIDTH - 1));

  // Result register shifts right with the new bit entering at the MSB;
  // written as shift-then-overwrite so WIDTH=1 needs no special case.
  always_comb begin
    diff_sh            = diff_q >> 1;
    diff_sh[WIDTH-1]   = d;
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // Next-state: start only matters in IDLE, so it is never queued.
  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:    if (start) state_nxt = SHIFT;
      SHIFT:   if (last)  state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Datapath: load on accepted start, one bit per edge in SHIFT, hold otherwise.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_q    <= '0;
      b_q    <= '0;
      diff_q <= '0;
      bin_q  <= 1'b0;
      cnt_q  <= '0;
    end else begin
      unique case (state)
        IDLE: if (start) begin
          a_q   <= a;
          b_q   <= b;
          bin_q <= 1'b0;
          cnt_q <= '0;
        end
        SHIFT: begin
          diff_q <= diff_sh;
          bin_q  <= bout;
          a_q    <= a_q >> 1;
          b_q    <= b_q >> 1;
          cnt_q  <= cnt_q + CW'(1);
        end
        default: ;
      endcase
    end
  end

  assign diff   = diff_q;
  assign borrow = bin_q;
  assign busy   = (state != IDLE);
  assign done   = (state == DONE);

endmodule

// File: tb/tb_serial_subtractor.sv
// Self-checking bench: WIDTH=8 and WIDTH=1 instances, queue scoreboard per DUT.
module tb_serial_subtractor;

  logic       clk, rst_n;
  logic       start8, start1;
  logic [7:0] a8, b8, diff8;
  logic [0:0] a1, b1, diff1;
  logic       borrow8, busy8, done8;
  logic       borrow1, busy1, done1;

  int tests = 0, fails = 0;
  int cyc = 0;
  int done8_cnt = 0, done1_cnt = 0;

  typedef struct { logic [7:0] d; logic br; } exp_t;
  typedef struct { logic [7:0] a; logic [7:0] b; logic [7:0] d; logic br; } vec_t;

  exp_t sb8[$];
  exp_t sb1[$];

  serial_subtractor #(.WIDTH(8)) dut8 (
    .clk(clk), .rst_n(rst_n), .start(start8), .a(a8), .b(b8),
    .diff(diff8), .borrow(borrow8), .busy(busy8), .done(done8)
  );

  serial_subtractor #(.WIDTH(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .start(start1), .a(a1), .b(b1),
    .diff(diff1), .borrow(borrow1), .busy(busy1), .done(done1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Scoreboard for the 8-bit DUT: every done pulse must match the oldest request.
  always @(negedge clk) begin
    if (done8 === 1'b1) begin
      exp_t e;
      done8_cnt++;
      if (sb8.size() == 0) begin
        tests++; fails++;
        $display("FAIL spurious_done8: got done with empty scoreboard (t=%0t)", $time);
      end else begin
        e = sb8.pop_front();
        chk("res_diff8", 32'(diff8), 32'(e.d));
        chk("res_borrow8", 32'(borrow8), 32'(e.br));
      end
    end
  end

  // Scoreboard for the 1-bit DUT.
  always @(negedge clk) begin
    if (done1 === 1'b1) begin
      exp_t e;
      done1_cnt++;
      if (sb1.size() == 0) begin
        tests++; fails++;
        $display("FAIL spurious_done1: got done with empty scoreboard (t=%0t)", $time);
      end else begin
        e = sb1.pop_front();
        chk("res_diff1", 32'(diff1), 32'(e.d[0]));
        chk("res_borrow1", 32'(borrow1), 32'(e.br));
      end
    end
  end

  // Wait (bounded) at negedges for done8; returns negedges counted including the first.
  task automatic wait_done8(output int n);
    n = 1;
    while (done8 !== 1'b1 && n < 40) begin @(negedge clk); n++; end
    if (done8 !== 1'b1) chk("timeout_done8", 32'(n), 32'd9);
  endtask

  task automatic op8(input logic [7:0] ia, input logic [7:0] ib,
                     input logic [7:0] ed, input logic eb);
    int n;
    @(negedge clk);
    chk("idle_busy8", 32'(busy8), 32'd0);
    a8 = ia; b8 = ib; start8 = 1'b1;
    sb8.push_back('{d: ed, br: eb});
    @(negedge clk);
    start8 = 1'b0;
    a8 = ~ia; b8 = ~ib;            // operands must already be captured
    chk("busy8", 32'(busy8), 32'd1);
    wait_done8(n);
    chk("latency8", 32'(n), 32'd9);
    @(negedge clk);
    chk("busy_after8", 32'(busy8), 32'd0);
    chk("done_after8", 32'(done8), 32'd0);
    chk("hold_diff8", 32'(diff8), 32'(ed));
    chk("hold_borrow8", 32'(borrow8), 32'(eb));
  endtask

  task automatic op1(input logic ia, input logic ib, input logic ed, input logic eb);
    int n;
    @(negedge clk);
    a1 = ia; b1 = ib; start1 = 1'b1;
    sb1.push_back('{d: {7'd0, ed}, br: eb});
    @(negedge clk);
    start1 = 1'b0;
    a1 = ~ia; b1 = ~ib;
    n = 1;
    while (done1 !== 1'b1 && n < 20) begin @(negedge clk); n++; end
    chk("latency1", 32'(n), 32'd2);
    @(negedge clk);
    chk("busy_after1", 32'(busy1), 32'd0);
  endtask

  initial begin
    vec_t vt[8];
    int   n, dc, t_prev;
    exp_t nxt[3];

    vt[0] = '{a: 8'd100, b: 8'd37,  d: 8'd63,  br: 1'b0};
    vt[1] = '{a: 8'd37,  b: 8'd100, d: 8'hC1,  br: 1'b1};
    vt[2] = '{a: 8'd0,   b: 8'd255, d: 8'd1,   br: 1'b1};
    vt[3] = '{a: 8'd0,   b: 8'd0,   d: 8'd0,   br: 1'b0};
    vt[4] = '{a: 8'd255, b: 8'd255, d: 8'd0,   br: 1'b0};
    vt[5] = '{a: 8'd255, b: 8'd0,   d: 8'd255, br: 1'b0};
    vt[6] = '{a: 8'd1,   b: 8'd2,   d: 8'd255, br: 1'b1};
    vt[7] = '{a: 8'd128, b: 8'd1,   d: 8'd127, br: 1'b0};

    rst_n = 1'b0; start8 = 1'b0; start1 = 1'b0;
    a8 = '0; b8 = '0; a1 = '0; b1 = '0;
    #1;
    chk("rst_diff8", 32'(diff8), 32'd0);
    chk("rst_borrow8", 32'(borrow8), 32'd0);
    chk("rst_busy8", 32'(busy8), 32'd0);
    chk("rst_done8", 32'(done8), 32'd0);
    chk("rst_busy1", 32'(busy1), 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    // Table-driven 8-bit results
    for (int i = 0; i < 8; i++) op8(vt[i].a, vt[i].b, vt[i].d, vt[i].br);

    // start pulsed mid-SHIFT with new operands must be ignored
    dc = done8_cnt;
    @(negedge clk);
    a8 = 8'd37; b8 = 8'd100; start8 = 1'b1;
    sb8.push_back('{d: 8'hC1, br: 1'b1});
    @(negedge clk); start8 = 1'b0;
    repeat (2) @(negedge clk);
    a8 = 8'd5; b8 = 8'd1; start8 = 1'b1;
    @(negedge clk); start8 = 1'b0;
    wait_done8(n);
    repeat (4) @(negedge clk);
    chk("ignore_one_done", 32'(done8_cnt - dc), 32'd1);
    chk("ignore_idle", 32'(busy8), 32'd0);

    // Reset in the middle of SHIFT aborts without a done pulse
    @(negedge clk);
    a8 = 8'd200; b8 = 8'd50; start8 = 1'b1;
    sb8.push_back('{d: 8'd150, br: 1'b0});
    @(negedge clk); start8 = 1'b0;
    repeat (4) @(negedge clk);
    chk("pre_abort_busy", 32'(busy8), 32'd1);
    dc = done8_cnt;
    rst_n = 1'b0;
    #1;
    chk("abort_diff", 32'(diff8), 32'd0);
    chk("abort_borrow", 32'(borrow8), 32'd0);
    chk("abort_busy", 32'(busy8), 32'd0);
    chk("abort_done", 32'(done8), 32'd0);
    sb8.delete();
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (12) @(negedge clk);
    chk("abort_no_done", 32'(done8_cnt - dc), 32'd0);
    op8(8'd200, 8'd50, 8'd150, 1'b0);

    // start held high: back-to-back ops, done spaced WIDTH+2 cycles
    nxt[0] = '{d: 8'd7,   br: 1'b0};
    nxt[1] = '{d: 8'd249, br: 1'b1};
    nxt[2] = '{d: 8'd0,   br: 1'b0};
    @(negedge clk);
    a8 = 8'd10; b8 = 8'd3; start8 = 1'b1;
    sb8.push_back(nxt[0]);
    t_prev = 0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      wait_done8(n);
      if (i > 0) chk("b2b_spacing", 32'(cyc - t_prev), 32'd10);
      t_prev = cyc;
      if (i == 0)      begin a8 = 8'd3;   b8 = 8'd10;  sb8.push_back(nxt[1]); end
      else if (i == 1) begin a8 = 8'd128; b8 = 8'd128; sb8.push_back(nxt[2]); end
      else start8 = 1'b0;
    end
    repeat (3) @(negedge clk);
    chk("b2b_stop_idle", 32'(busy8), 32'd0);

    // WIDTH=1 exhaustive
    op1(1'b0, 1'b0, 1'b0, 1'b0);
    op1(1'b0, 1'b1, 1'b1, 1'b1);
    op1(1'b1, 1'b0, 1'b1, 1'b0);
    op1(1'b1, 1'b1, 1'b0, 1'b0);
    chk("done1_count", 32'(done1_cnt), 32'd4);

    repeat (2) @(negedge clk);
    chk("sb8_empty", 32'(sb8.size()), 32'd0);
    chk("sb1_empty", 32'(sb1.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
